e3_serial_adder_ctrl: RTL
=========================

# e3_serial_adder_ctrl

Sequencer that performs multi-digit Excess-3 (E3) BCD addition and subtraction by time-sharing a single 4-bit E3 digit adder cell. Operands are processed one digit per clock, least-significant digit first, with the inter-digit carry held in a register. The block sits between a host that issues `start` with packed E3 operands and the combinational E3 digit adder cell (x, y, ci -> z, co) it instantiates once. It returns a packed E3 result, a decimal carry/borrow flag and an invalid-code error flag.

## Interface

Parameters:
- `DIGITS`, default 4: number of E3 digits per operand; must be ≥ 1.

Ports:
- `clk`  in  1  single clock; all state changes on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  1  0 = add, 1 = subtract (x − y); captured with `start`.
- `ci`  in  1  carry-in for add; ignored for subtract; captured with `start`.
- `x`  in  4*DIGITS  operand, packed E3 digits, digit 0 in bits [3:0]; captured with `start`.
- `y`  in  4*DIGITS  operand, same packing; captured with `start`.
- `z`  out  4*DIGITS  result, packed E3 digits.
- `co`  out  1  add: decimal carry-out; subtract: 1 = no borrow (x ≥ y), 0 = negative result in ten's complement.
- `busy`  out  1  high in RUN and DONE.
- `done`  out  1  one-cycle completion pulse.
- `err`  out  1  operand contained an invalid E3 code; valid while `done` is high and held until next accepted `start`.

## Operation

- States: IDLE, RUN, DONE. Reset enters IDLE.
- Reset values: `z` = all digits 4'h3 (decimal 0), `co` = 0, `busy` = 0, `done` = 0, `err` = 0; digit counter = 0; carry register = 0.
- IDLE + `start`=1: capture `x`, `y`, `op`, `ci`; check every digit of `x` and `y` for the valid E3 range 4'h3..4'hC.
  - Any invalid digit: go to DONE, `err`=1, `z` = all 4'h3, `co`=0.
  - All valid: go to RUN, `err`=0, counter=0, carry register = `ci` (add) or 1 (subtract).
- RUN, per cycle with counter k: cell inputs are x digit k; y digit k (add) or bitwise-inverted y digit k (subtract, E3 nine's complement); carry register. The cell's sum is written to `z` digit k and its carry to the carry register. Counter increments.
- After digit DIGITS−1 is written, `co` = final carry, go to DONE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `z`, `co`, `err` hold until the next accepted `start`.
- `start` in RUN or DONE: ignored, with no effect on captured operands.
- Digits of `z` not yet written during RUN keep their previous values; only the final `z` is defined.
- Async reset mid-operation: immediately returns to reset values; in-flight operation discarded; no `done`.

## Timing

- Edge E0 samples `start`=1 in IDLE; `busy` rises after E0.
- Valid operands: edges E1..E_DIGITS write digits 0..DIGITS−1. `done` is high in the cycle following E_DIGITS, which is DIGITS+1 edges after the start edge. `busy` falls after E_DIGITS+1.
- Invalid operands: `done` and `err` are high in the cycle following E0; `busy` falls after E1.
- Earliest next `start` is sampled at the first edge in IDLE; throughput is one operation per DIGITS+2 cycles.
- `z` and `co` are stable and correct whenever `done`=1.

## Test plan

- Add, DIGITS=4, `x`=16'h4567 (1234), `y`=16'h89AB (5678), `ci`=0 -> `z`=16'h9C45 (6912), `co`=0, `done` exactly 5 edges after start edge, `err`=0.
- Add 9999 + 0001: `x`=16'hCCCC, `y`=16'h3334, `ci`=0 -> `z`=16'h3333, `co`=1. Repeat with `ci`=1 and `y`=16'h3333 -> same result.
- Subtract 5000 − 1234 (`x`=16'h8333, `y`=16'h4567) -> `z`=16'h6A99 (3766), `co`=1. Subtract 0001 − 0002 -> `z`=16'hCCCC (9999), `co`=0.
- Invalid code: `x`=16'h33F3 -> `done`=1 and `err`=1 in the cycle after the start edge, `z`=16'h3333, `co`=0. The next valid add clears `err`.
- `start` held high through RUN with changing `x`/`y` -> result reflects only the first captured operands; exactly one `done` pulse; a new operation begins only after return to IDLE.
- `rst_n` pulsed low during RUN (after 2 digits) -> all outputs at reset values asynchronously, no `done`. A subsequent operation completes correctly.

Source files
------------

// File: rtl/e3_serial_adder_ctrl.sv
// Multi-digit Excess-3 BCD add/subtract sequencer built around one shared E3 digit adder cell.
// Digits are processed LSD first, one per clock, with the inter-digit carry kept in a register.

module e3_digit_adder (
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       ci,
    output logic [3:0] z,
    output logic       co
);
    logic [4:0] sum;

    // Two E3 digits carry a +6 bias: a binary carry means a decimal carry (re-add 3),
    // otherwise the surplus 3 is removed to restore the single E3 bias.
    assign sum = {1'b0, x} + {1'b0, y} + {4'b0000, ci};
    assign co  = sum[4];
    assign z   = sum[4] ? (sum[3:0] + 4'd3) : (sum[3:0] - 4'd3);
endmodule

module e3_serial_adder_ctrl #(
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  op,
    input  logic                  ci,
    input  logic [4*DIGITS-1:0]   x,
    input  logic [4*DIGITS-1:0]   y,
    output logic [4*DIGITS-1:0]   z,
    output logic                  co,
    output logic                  busy,
    output logic                  done,
    output logic                  err
);
    localparam int W  = 4 * DIGITS;
    localparam int CW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state, next_state;
    logic [W-1:0]    x_q, y_q;
    logic            op_q;
    logic            carry_q;
    logic [CW-1:0]   cnt_q;

    logic [3:0]      x_dig, y_dig, cell_y, cell_z;
    logic            cell_co;
    logic            ops_valid;
    logic            last_digit;

    function automatic logic all_e3(input logic [W-1:0] a, input logic [W-1:0] b);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (a[4*i +: 4] < 4'h3 || a[4*i +: 4] > 4'hC) ok = 1'b0;
            if (b[4*i +: 4] < 4'h3 || b[4*i +: 4] > 4'hC) ok = 1'b0;
        end
        return ok;
    endfunction

    assign ops_valid  = all_e3(x, y);
    assign last_digit = (cnt_q == CW'(DIGITS - 1));

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        x_dig = 4'h3;
        y_dig = 4'h3;
        for (int i = 0; i < DIGITS; i++) begin
            if (cnt_q == CW'(i)) begin
                x_dig = x_q[4*i +: 4];
                y_dig = y_q[4*i +: 4];
            end
        end
    end

    // Inverting an E3 digit yields its nine's complement; the initial carry of 1 makes it ten's.
    assign cell_y = op_q ? ~y_dig : y_dig;

    e3_digit_adder u_cell (
        .x  (x_dig),
        .y  (cell_y),
        .ci (carry_q),
        .z  (cell_z),
        .co (cell_co)
    );

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (start) next_state = ops_valid ? S_RUN : S_DONE;
            S_RUN:  if (last_digit) next_state = S_DONE;
            S_DONE: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q     <= '0;
            y_q     <= '0;
            op_q    <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            z       <= {DIGITS{4'h3}};
            co      <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        x_q   <= x;
                        y_q   <= y;
                        op_q  <= op;
                        cnt_q <= '0;
                        if (!ops_valid) begin
                            err <= 1'b1;
                            z   <= {DIGITS{4'h3}};
                            co  <= 1'b0;
                        end else begin
                            err     <= 1'b0;
                            carry_q <= op ? 1'b1 : ci;
                        end
                    end
                end
                S_RUN: begin
                    for (int i = 0; i < DIGITS; i++) begin
                        if (cnt_q == CW'(i)) z[4*i +: 4] <= cell_z;
                    end
                    carry_q <= cell_co;
                    if (last_digit) begin
                        co    <= cell_co;
                        cnt_q <= '0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);
endmodule
